// File: rtl/imem_uart_loader.sv
// Loads a program image from UART bytes into the 64-word instruction store and holds the CPU in reset meanwhile.
// Latency: wr_en pulses exactly one cycle after the 4th byte of each word is received.
// No backpressure: a byte may arrive every cycle and is always accepted; a stalled frame aborts on timeout.
module imem_uart_loader #(
  parameter int          ADDR_W     = 6,
  parameter logic [7:0]  START_BYTE = 8'hA5,
  parameter int          TOUT_CYC   = 1000000,
  parameter int          TOUT_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word_idx, word_idx_nxt;
  logic [ADDR_W-1:0] last_idx, last_idx_nxt;   // index of the final word (N-1)
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [23:0]       word_sr, word_sr_nxt;     // first three bytes of the word in flight
  logic [7:0]        csum, csum_nxt;
  logic [TOUT_W-1:0] tout, tout_nxt;
  logic              wr_en_nxt, cpu_hold_nxt, load_done_nxt, load_error_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [31:0]       wr_data_nxt;

  // State and every output are registered; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      last_idx   <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      csum       <= '0;
      tout       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_idx   <= word_idx_nxt;
      last_idx   <= last_idx_nxt;
      byte_idx   <= byte_idx_nxt;
      word_sr    <= word_sr_nxt;
      csum       <= csum_nxt;
      tout       <= tout_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      cpu_hold   <= cpu_hold_nxt;
      load_done  <= load_done_nxt;
      load_error <= load_error_nxt;
    end
  end

  // Frame parser: next state, datapath updates and next output values.
  always_comb begin
    state_nxt      = state;
    word_idx_nxt   = word_idx;
    last_idx_nxt   = last_idx;
    byte_idx_nxt   = byte_idx;
    word_sr_nxt    = word_sr;
    csum_nxt       = csum;
    tout_nxt       = '0;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    cpu_hold_nxt   = cpu_hold;
    load_done_nxt  = load_done;
    load_error_nxt = load_error;

    case (state)
      S_IDLE: begin
        // CPU runs only after a successful load
        cpu_hold_nxt = ~load_done;
        if (rx_valid && rx_data == START_BYTE) begin
          cpu_hold_nxt   = 1'b1;
          load_done_nxt  = 1'b0;
          load_error_nxt = 1'b0;
          csum_nxt       = '0;
          word_idx_nxt   = '0;
          byte_idx_nxt   = '0;
          state_nxt      = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
            state_nxt = S_ERROR;
          end else begin
            last_idx_nxt = ADDR_W'(rx_data - 8'd1);
            state_nxt    = S_DATA;
          end
        end
      end
      S_DATA: begin
        // START_BYTE here is ordinary data, never a resync
        if (rx_valid) begin
          word_sr_nxt  = {word_sr[15:0], rx_data};
          csum_nxt     = csum ^ rx_data;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_en_nxt    = 1'b1;
            wr_data_nxt  = {word_sr, rx_data};
            wr_addr_nxt  = word_idx;
            word_idx_nxt = word_idx + 1'b1;
            if (word_idx == last_idx)
              state_nxt = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid)
          state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        load_done_nxt = 1'b1;
        cpu_hold_nxt  = 1'b0;
        state_nxt     = S_IDLE;
      end
      S_ERROR: begin
        // Words already written stay in memory; CPU remains held
        load_error_nxt = 1'b1;
        cpu_hold_nxt   = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Inter-byte timeout, only while a frame is in progress
    if (state == S_COUNT || state == S_DATA || state == S_CSUM) begin
      if (rx_valid) begin
        tout_nxt = '0;
      end else if (tout == TOUT_W'(TOUT_CYC - 1)) begin
        tout_nxt  = '0;
        state_nxt = S_ERROR;
      end else begin
        tout_nxt = tout + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frames are driven byte-wise, writes are captured
// by a monitor and compared against hand-derived words, addresses and status flags.
module tb_imem_uart_loader;
  localparam int TOUT = 40;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [7:0]  fb[$];
  int          drv_cyc[$];
  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [31:0] exp_w[64];

  imem_uart_loader #(.ADDR_W(6), .START_BYTE(8'hA5), .TOUT_CYC(TOUT), .TOUT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write pulse mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive fb, with 'gap' idle cycles after each byte
  task automatic send(input int gap);
    drv_cyc.delete();
    for (int i = 0; i < fb.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = fb[i];
      drv_cyc.push_back(cyc);
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clr_wr();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  // Example two-word program; checksum computed from data bytes (0x5B) unless bad
  task automatic frame_a(input bit bad);
    logic [7:0] cs;
    fb = '{8'hA5, 8'h02, 8'h20, 8'h09, 8'h00, 8'h32, 8'h01, 8'h29, 8'h48, 8'h20};
    cs = 8'h00;
    for (int i = 2; i < 10; i++) cs = cs ^ fb[i];
    fb.push_back(bad ? 8'h00 : cs);
  endtask

  task automatic check_frame_a(input string tag);
    check({tag, "_nwr"}, wa.size(), 2);
    if (wa.size() >= 2) begin
      check({tag, "_a0"}, {26'd0, wa[0]}, 0);
      check({tag, "_d0"}, wd[0], 32'h20090032);
      check({tag, "_a1"}, {26'd0, wa[1]}, 1);
      check({tag, "_d1"}, wd[1], 32'h01294820);
    end
  endtask

  initial begin
    logic [7:0] b, cs;
    rst_n    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_wr_addr", {26'd0, wr_addr}, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_hold", {31'd0, cpu_hold}, 1);
    check("rst_done", {31'd0, load_done}, 0);
    check("rst_err", {31'd0, load_error}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame, one idle cycle between bytes
    clr_wr();
    frame_a(1'b0);
    send(1);
    repeat (4) @(negedge clk);
    check_frame_a("good");
    if (wc.size() >= 1) check("good_lat", wc[0], drv_cyc[5] + 1);
    check("good_done", {31'd0, load_done}, 1);
    check("good_hold", {31'd0, cpu_hold}, 0);
    check("good_err", {31'd0, load_error}, 0);

    // COUNT = 0
    clr_wr();
    fb = '{8'hA5, 8'h00};
    send(0);
    repeat (4) @(negedge clk);
    check("cnt0_nwr", wa.size(), 0);
    check("cnt0_err", {31'd0, load_error}, 1);
    check("cnt0_done", {31'd0, load_done}, 0);
    check("cnt0_hold", {31'd0, cpu_hold}, 1);

    // 64 words back-to-back, data includes START_BYTE values
    clr_wr();
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'd64);
    cs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      exp_w[i] = {b, 8'hA5, b ^ 8'h3C, 8'hC3 - b};
      for (int k = 3; k >= 0; k--) begin
        fb.push_back(exp_w[i][8*k +: 8]);
        cs = cs ^ exp_w[i][8*k +: 8];
      end
    end
    fb.push_back(cs);
    send(0);
    repeat (4) @(negedge clk);
    check("n64_nwr", wa.size(), 64);
    for (int i = 0; i < wa.size() && i < 64; i++) begin
      check("n64_addr", {26'd0, wa[i]}, i);
      check("n64_data", wd[i], exp_w[i]);
    end
    if (wc.size() >= 64) begin
      check("n64_lat", wc[0], drv_cyc[5] + 1);
      check("n64_span", wc[63] - wc[0], 252);
    end
    check("n64_done", {31'd0, load_done}, 1);
    check("n64_err", {31'd0, load_error}, 0);

    // COUNT = 0x41 (one more than depth)
    clr_wr();
    fb = '{8'hA5, 8'h41};
    send(0);
    repeat (4) @(negedge clk);
    check("cnt41_nwr", wa.size(), 0);
    check("cnt41_err", {31'd0, load_error}, 1);
    check("cnt41_hold", {31'd0, cpu_hold}, 1);

    // Bad checksum: writes still issued
    clr_wr();
    frame_a(1'b1);
    send(0);
    repeat (4) @(negedge clk);
    check_frame_a("badcs");
    check("badcs_err", {31'd0, load_error}, 1);
    check("badcs_done", {31'd0, load_done}, 0);
    check("badcs_hold", {31'd0, cpu_hold}, 1);

    // Timeout after two data bytes
    clr_wr();
    fb = '{8'hA5, 8'h01, 8'h11, 8'h22};
    send(0);
    repeat (TOUT - 2) @(negedge clk);
    check("tout_early", {31'd0, load_error}, 0);
    repeat (4) @(negedge clk);
    check("tout_err", {31'd0, load_error}, 1);
    check("tout_hold", {31'd0, cpu_hold}, 1);
    check("tout_nwr", wa.size(), 0);
    clr_wr();
    frame_a(1'b0);
    send(0);
    repeat (4) @(negedge clk);
    check_frame_a("after_tout");
    check("after_tout_done", {31'd0, load_done}, 1);

    // New frame re-asserts hold; reset during the third word
    clr_wr();
    fb = '{8'hA5};
    send(0);
    check("rehold", {31'd0, cpu_hold}, 1);
    fb = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    send(1);
    check("mid_nwr", wa.size(), 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_wr_en", {31'd0, wr_en}, 0);
    check("mid_wr_addr", {26'd0, wr_addr}, 0);
    check("mid_wr_data", wr_data, 0);
    check("mid_hold", {31'd0, cpu_hold}, 1);
    check("mid_done", {31'd0, load_done}, 0);
    check("mid_err", {31'd0, load_error}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_nwr_after", wa.size(), 2);
    clr_wr();
    frame_a(1'b0);
    send(0);
    repeat (4) @(negedge clk);
    check_frame_a("post_rst");
    check("post_rst_done", {31'd0, load_done}, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
